// File: rtl/sd_dfc_pkg.sv
// sd_dfc_pkg: shared constants and round-robin grant helper for the DFC rate-controlled arbiter
package sd_dfc_pkg;
  localparam int RC_CTR_SZ_DEF = 8;
  function automatic logic [15:0] rr_grant(input logic [15:0] req, input int ptr, input int n);
    logic [15:0] g;
    logic hit;
    logic [3:0] k;
    g = '0;
    hit = 1'b0;
    for (int o = 0; o < 16; o++) begin
      k = 4'((ptr + o) % n);
      if (o < n && !hit && req[k]) begin
        g[k] = 1'b1;
        hit = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/sd_dfc_rcarb_if.sv
// sd_dfc_rcarb_if: requester, DFC link and rate/monitor configuration bundle
interface sd_dfc_rcarb_if #(
  parameter int inputs = 4,
  parameter int width = 8,
  parameter int rc_ctr_sz = 8
);
  logic [rc_ctr_sz-1:0] window_size;
  logic [inputs*rc_ctr_sz-1:0] rc_max_tx;
  logic [rc_ctr_sz-1:0] mon_fc_thd;
  logic [inputs-1:0] c_srdy;
  logic [inputs-1:0] c_drdy;
  logic [inputs*width-1:0] c_data;
  logic p_vld;
  logic [width-1:0] p_data;
  logic [$clog2(inputs)-1:0] p_src;
  logic p_fc_n;
  logic [inputs-1:0] throttled;
  logic [inputs-1:0] mon_triggered;
  modport slave (
    input window_size, rc_max_tx, mon_fc_thd, c_srdy, c_data, p_fc_n,
    output c_drdy, p_vld, p_data, p_src, throttled, mon_triggered
  );
  modport master (
    output window_size, rc_max_tx, mon_fc_thd, c_srdy, c_data, p_fc_n,
    input c_drdy, p_vld, p_data, p_src, throttled, mon_triggered
  );
endinterface

// File: rtl/sd_dfc_rc_window.sv
// sd_dfc_rc_window: rate window counter with per-port saturating transfer counters and throttle flags
module sd_dfc_rc_window #(
  parameter int inputs = 4,
  parameter int rc_ctr_sz = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [rc_ctr_sz-1:0] window_size_i,
  input  logic [inputs*rc_ctr_sz-1:0] rc_max_tx_i,
  input  logic [inputs-1:0] xfer_i,
  output logic boundary_o,
  output logic [inputs-1:0] throttled_o
);
  logic [rc_ctr_sz-1:0] win_q, win_d;
  logic [inputs-1:0][rc_ctr_sz-1:0] tx_q, tx_d;
  always_comb begin
    boundary_o = window_size_i <= rc_ctr_sz'(1) || win_q >= window_size_i - 1'b1;
    win_d = boundary_o ? '0 : win_q + 1'b1;
    tx_d = tx_q;
    throttled_o = '0;
    for (int i = 0; i < inputs; i++) begin
      tx_d[i] = boundary_o ? rc_ctr_sz'(xfer_i[i]) : (xfer_i[i] && ~&tx_q[i]) ? tx_q[i] + 1'b1 : tx_q[i];
      throttled_o[i] = |rc_max_tx_i[i*rc_ctr_sz +: rc_ctr_sz] && tx_q[i] >= rc_max_tx_i[i*rc_ctr_sz +: rc_ctr_sz];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      tx_q <= '0;
    end else begin
      win_q <= win_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: rtl/sd_dfc_rcarb.sv
// sd_dfc_rcarb: round-robin DFC arbiter with per-port rate windows; define SD_DFC_RCARB_MON_EN for the starvation monitor
module sd_dfc_rcarb
  import sd_dfc_pkg::*;
#(
  parameter int inputs = 4,
  parameter int width = 8,
  parameter int rc_ctr_sz = RC_CTR_SZ_DEF
) (
  input logic clk,
  input logic rst,
  sd_dfc_rcarb_if.slave bus
);
  localparam int sw = $clog2(inputs);
  logic [sw-1:0] ptr_q, ptr_d, src_d, p_src_q;
  logic [inputs-1:0] elig, grant, xfer, thr;
  logic [15:0] rr;
  logic boundary, p_vld_q;
  logic [width-1:0] p_data_d, p_data_q;
  assign elig = bus.c_srdy & ~thr;
  assign rr = rr_grant(16'(elig), int'(ptr_q), inputs);
  assign grant = (bus.p_fc_n && !rst) ? rr[inputs-1:0] : '0;
  assign bus.c_drdy = grant;
  assign xfer = bus.c_srdy & grant;
  assign bus.p_vld = p_vld_q;
  assign bus.p_data = p_data_q;
  assign bus.p_src = p_src_q;
  assign bus.throttled = thr;
  always_comb begin
    src_d = '0;
    p_data_d = '0;
    for (int i = 0; i < inputs; i++)
      if (grant[i]) begin
        src_d = sw'(i);
        p_data_d = bus.c_data[i*width +: width];
      end
    ptr_d = |xfer ? (src_d == sw'(inputs - 1) ? '0 : src_d + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      p_vld_q <= 1'b0;
      p_data_q <= '0;
      p_src_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      p_vld_q <= |xfer;
      if (|xfer) begin
        p_data_q <= p_data_d;
        p_src_q <= src_d;
      end
    end
  end
  sd_dfc_rc_window #(.inputs(inputs), .rc_ctr_sz(rc_ctr_sz)) u_win (
    .clk(clk),
    .rst(rst),
    .window_size_i(bus.window_size),
    .rc_max_tx_i(bus.rc_max_tx),
    .xfer_i(xfer),
    .boundary_o(boundary),
    .throttled_o(thr)
  );
`ifdef SD_DFC_RCARB_MON_EN
  logic [inputs-1:0][rc_ctr_sz-1:0] fc_q, fc_d;
  logic [inputs-1:0] mon_q, mon_d, stall;
  always_comb begin
    stall = bus.c_srdy & ~bus.c_drdy;
    fc_d = fc_q;
    mon_d = '0;
    for (int i = 0; i < inputs; i++) begin
      fc_d[i] = boundary ? rc_ctr_sz'(stall[i]) : (stall[i] && ~&fc_q[i]) ? fc_q[i] + 1'b1 : fc_q[i];
      mon_d[i] = fc_d[i] > bus.mon_fc_thd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q <= '0;
      mon_q <= '0;
    end else begin
      fc_q <= fc_d;
      mon_q <= mon_d;
    end
  end
  assign bus.mon_triggered = mon_q;
`else
  logic unused_thd;
  assign unused_thd = ^{bus.mon_fc_thd, boundary};
  assign bus.mon_triggered = '0;
`endif
`ifdef SIMULATION
  logic fc_q1;
  always_ff @(posedge clk) fc_q1 <= bus.p_fc_n;
  always_ff @(posedge clk) if (p_vld_q) assert (fc_q1);
`endif
endmodule
